// File: rtl/imm_ext_pipe.sv
// Pipelined RISC-V immediate generator with a registered valid/ready output and 2-entry skid buffer.
// Optional macro IMM_EXT_ZIMM_EN enables fmt 5 (CSR zimm); without it fmt 5 is illegal.
module imm_ext_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state, state_nxt;

    logic            accept, pop;
    logic            load_main, load_skid, move_skid;
    logic [63:0]     ext64;
    logic            ext_ill;
    logic [XLEN-1:0] ext_imm;

    logic [XLEN-1:0]  skid_imm;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    // Opcode bits never feed an immediate
    logic unused_opcode;
    assign unused_opcode = ^in_inst[6:0];

    always_comb begin
        ext64   = '0;
        ext_ill = 1'b0;
        case (in_fmt)
            3'd0: ext64 = {{52{in_inst[31]}}, in_inst[31:20]};
            3'd1: ext64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'd2: ext64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
            3'd3: ext64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
            3'd4: ext64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
`ifdef IMM_EXT_ZIMM_EN
            3'd5: ext64 = {59'b0, in_inst[19:15]};
`else
            3'd5: ext_ill = 1'b1;
`endif
            default: ext_ill = 1'b1;
        endcase
    end

    // Narrower XLEN simply keeps the low bits of the 64-bit sign extension
    assign ext_imm = ext64[XLEN-1:0];

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    move_skid = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Main slot drives the outputs; it holds whenever nothing is loaded or moved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm     <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            skid_imm    <= '0;
            skid_ill    <= 1'b0;
            skid_tag    <= '0;
        end else begin
            if (load_main) begin
                out_imm     <= ext_imm;
                out_illegal <= ext_ill;
                out_tag     <= in_tag;
            end else if (move_skid) begin
                out_imm     <= skid_imm;
                out_illegal <= skid_ill;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= ext_imm;
                skid_ill <= ext_ill;
                skid_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= 8'd0;
        else if (accept && ext_ill && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed testbench for imm_ext_pipe: formats, backpressure, illegal counting, reset mid-transfer.
// A second XLEN=32 instance shares the stimulus to check the narrow-width result.
module tb_imm_ext_pipe;

    localparam int TAG_W = 5;
`ifdef IMM_EXT_ZIMM_EN
    localparam bit ZIMM_ON = 1'b1;
`else
    localparam bit ZIMM_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [2:0]       in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready, out_valid, out_illegal;
    logic [63:0]      out_imm;
    logic [TAG_W-1:0] out_tag;
    logic [7:0]       err_cnt;

    logic             in_ready32, out_valid32, out_illegal32;
    logic [31:0]      out_imm32;
    logic [TAG_W-1:0] out_tag32;
    logic [7:0]       err_cnt32;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    always #5 clk = ~clk;

    imm_ext_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_illegal(out_illegal), .out_tag(out_tag), .err_cnt(err_cnt)
    );

    imm_ext_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
        .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_illegal(out_illegal32), .out_tag(out_tag32), .err_cnt(err_cnt32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_fmt = '0; in_tag = '0; out_ready = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %0b want 1", in_ready); end
        checks++; if (out_imm !== 64'd0) begin errors++; $display("[TB] FAIL rst_imm got %h want 0", out_imm); end
        checks++; if (out_illegal !== 1'b0) begin errors++; $display("[TB] FAIL rst_illegal got %0b want 0", out_illegal); end
        checks++; if (out_tag !== '0) begin errors++; $display("[TB] FAIL rst_tag got %0d want 0", out_tag); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_err got %0d want 0", err_cnt); end
        rst = 1'b0;
        step();
        exp_err = 0;
    endtask

    // Back-to-back vectors with out_ready high: one result per cycle, one cycle latency
    task automatic test_formats();
        logic [31:0] v_inst [8];
        logic [2:0]  v_fmt  [8];
        logic [63:0] v_imm  [8];
        logic        v_ill  [8];
        logic [31:0] exp32;
        v_inst = '{32'hFFF00093, 32'h06400093, 32'hFE20BC23, 32'h00000463,
                   32'h800000B7, 32'hFFDFF06F, 32'h12345678, 32'hFFFFFFF3};
        v_fmt  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd5};
        v_imm  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 64'hFFFF_FFFF_FFFF_FFF8, 64'd8,
                   64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0,
                   ZIMM_ON ? 64'h1F : 64'd0};
        v_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, !ZIMM_ON};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_inst = v_inst[i]; in_fmt = v_fmt[i]; in_tag = TAG_W'(i + 1);
            step();
            if (v_ill[i]) exp_err++;
            exp32 = v_imm[i][31:0];
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fmt%0d_valid got %0b want 1", i, out_valid); end
            checks++; if (out_imm !== v_imm[i]) begin errors++; $display("[TB] FAIL fmt%0d_imm got %h want %h", i, out_imm, v_imm[i]); end
            checks++; if (out_illegal !== v_ill[i]) begin errors++; $display("[TB] FAIL fmt%0d_illegal got %0b want %0b", i, out_illegal, v_ill[i]); end
            checks++; if (out_tag !== TAG_W'(i + 1)) begin errors++; $display("[TB] FAIL fmt%0d_tag got %0d want %0d", i, out_tag, i + 1); end
            checks++; if (out_imm32 !== exp32) begin errors++; $display("[TB] FAIL fmt%0d_imm32 got %h want %h", i, out_imm32, exp32); end
            checks++; if (err_cnt !== 8'(exp_err)) begin errors++; $display("[TB] FAIL fmt%0d_err got %0d want %0d", i, err_cnt, exp_err); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fmt_drain_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_fmt = 3'd0; in_tag = 5'd1;
        step();
        in_inst = 32'h06400093; in_tag = 5'd2;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got %0b want 0", in_ready); end
        checks++; if (out_tag !== 5'd1) begin errors++; $display("[TB] FAIL bp_hold_tag got %0d want 1", out_tag); end
        // Offer a request while full; it must not be taken
        in_valid = 1'b1; in_inst = 32'h00000463; in_fmt = 3'd2; in_tag = 5'd9;
        step();
        in_valid = 1'b0;
        checks++; if (out_tag !== 5'd1) begin errors++; $display("[TB] FAIL bp_stable_tag got %0d want 1", out_tag); end
        checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL bp_stable_imm got %h want ffffffffffffffff", out_imm); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_stable_valid got %0b want 1", out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (out_tag !== 5'd2) begin errors++; $display("[TB] FAIL bp_second_tag got %0d want 2", out_tag); end
        checks++; if (out_imm !== 64'd100) begin errors++; $display("[TB] FAIL bp_second_imm got %h want 64", out_imm); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back got %0b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_extra got %0b want 0", out_valid); end
    endtask

    task automatic test_err_saturate();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'hDEADBEEF; in_fmt = 3'd6;
        for (int i = 0; i < 300; i++) begin
            in_tag = TAG_W'(i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_err got %0d want 255", err_cnt); end
        checks++; if (out_illegal !== 1'b1) begin errors++; $display("[TB] FAIL sat_illegal got %0b want 1", out_illegal); end
        checks++; if (out_imm !== 64'd0) begin errors++; $display("[TB] FAIL sat_imm got %h want 0", out_imm); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_fmt = 3'd0; in_tag = 5'd4;
        step();
        in_tag = 5'd5;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_pre_ready got %0b want 0", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %0b want 1", in_ready); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_err got %0d want 0", err_cnt); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale%0d got %0b want 0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_err_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
